// File: rtl/adder_error_sweeper.sv
// Sweeps every {op_a, op_b} pair through an external exact/approximate adder
// pair and accumulates vector count, error count, error sum and maximum error.
module adder_error_sweeper #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     sum_exact,
    input  logic [WIDTH:0]     sum_approx,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   vec_count,
    output logic [2*WIDTH:0]   err_count,
    output logic [3*WIDTH:0]   err_sum,
    output logic [WIDTH:0]     max_err,
    output logic [1:0]         dbg_state
);

    localparam int VW = 2 * WIDTH;

    // Control handshake: start is a level sampled only in IDLE/DONE and only
    // when abort is low; abort is sampled only in RUN/DRAIN and wins over
    // every other transition on the same edge. No backpressure exists.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [VW-1:0]    vec_idx;
    logic             last_vec;
    logic             kick;
    logic             capture;
    logic [WIDTH:0]   diff_now;
    logic             valid1;
    logic [WIDTH:0]   diff1;

    assign op_a      = vec_idx[VW-1:WIDTH];
    assign op_b      = vec_idx[WIDTH-1:0];
    assign last_vec  = &vec_idx;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        if (sum_exact >= sum_approx) begin
            diff_now = sum_exact - sum_approx;
        end else begin
            diff_now = sum_approx - sum_exact;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kick      = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_nxt = S_RUN;
                    kick      = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    capture = 1'b1;
                    if (last_vec) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once stage 2 has retired the final vector.
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!valid1) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand counter: the final vector's operands stay applied through DRAIN/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx <= '0;
        end else if (kick) begin
            vec_idx <= '0;
        end else if (capture && !last_vec) begin
            vec_idx <= vec_idx + {{(VW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1 <= 1'b0;
            diff1  <= '0;
        end else begin
            valid1 <= capture;
            if (capture) begin
                diff1 <= diff_now;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count <= '0;
            err_count <= '0;
            err_sum   <= '0;
            max_err   <= '0;
        end else if (kick) begin
            vec_count <= '0;
            err_count <= '0;
            err_sum   <= '0;
            max_err   <= '0;
        end else if (valid1) begin
            vec_count <= vec_count + {{VW{1'b0}}, 1'b1};
            err_count <= err_count + {{VW{1'b0}}, (diff1 != '0)};
            err_sum   <= err_sum + {{VW{1'b0}}, diff1};
            if (diff1 > max_err) begin
                max_err <= diff1;
            end
        end
    end

endmodule
